// File: rtl/lpddr2_arb_pkg.sv
// Shared state encoding, port indices and constants for the LPDDR2 port arbiter.
package lpddr2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection: a lone requester wins; a tie goes to port 1 when
// FIXED_PRIO is set, otherwise to the port that was not granted last.
module arb_pick2
  import lpddr2_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      grant = (FIXED_PRIO != 0) ? PORT_DATA : ~last_grant;
    end else begin
      grant = req[1] ? PORT_DATA : PORT_FETCH;
    end
  end

endmodule

// File: rtl/lpddr2_port_arbiter.sv
// Arbiter/sequencer for the single LPDDR2 word port shared by fetch (port 0) and
// data (port 1). Define LPDDR2_ARB_TIMEOUT_EN to bound the read-data wait.
module lpddr2_port_arbiter
  import lpddr2_arb_pkg::*;
#(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              busy,
  output logic              owner,
  output logic              err,
  output logic [ADDR_W-1:0] lpddr2_address,
  output logic [DATA_W-1:0] lpddr2_write_data,
  input  logic [DATA_W-1:0] lpddr2_read_data,
  output logic              lpddr2_rreq,
  output logic              lpddr2_wreq,
  input  logic              lpddr2_waitreq,
  input  logic              lpddr2_rvalid
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              pick_valid, pick_grant;

  arb_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

`ifdef LPDDR2_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timed_out;

  // The cycle that sees cnt_q == TIMEOUT-1 is the TIMEOUT-th RD_WAIT cycle.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err       = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0) | (|TIMEOUT_DATA);
  assign err            = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
`ifdef LPDDR2_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_grant;
          we_d    = (pick_grant == PORT_DATA) ? p1_we    : p0_we;
          addr_d  = (pick_grant == PORT_DATA) ? p1_addr  : p0_addr;
          wdata_d = (pick_grant == PORT_DATA) ? p1_wdata : p0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!lpddr2_waitreq) begin
          state_d = we_q ? DONE : RD_WAIT;
`ifdef LPDDR2_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RD_WAIT: begin
        if (lpddr2_rvalid) begin
          if (owner_q == PORT_DATA) p1_rdata_d = lpddr2_read_data;
          else                      p0_rdata_d = lpddr2_read_data;
          state_d = DONE;
        end
`ifdef LPDDR2_ARB_TIMEOUT_EN
        else if (timed_out) begin
          if (owner_q == PORT_DATA) p1_rdata_d = DATA_W'(TIMEOUT_DATA);
          else                      p0_rdata_d = DATA_W'(TIMEOUT_DATA);
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_FETCH;
      last_grant_q <= PORT_DATA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

`ifdef LPDDR2_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  // Strobes and done decode straight from state so reset drops them without waiting for an edge.
  assign busy              = (state_q != IDLE);
  assign lpddr2_rreq       = (state_q == ISSUE) && !we_q;
  assign lpddr2_wreq       = (state_q == ISSUE) &&  we_q;
  assign p0_done           = (state_q == DONE) && (owner_q == PORT_FETCH);
  assign p1_done           = (state_q == DONE) && (owner_q == PORT_DATA);
  assign owner             = owner_q;
  assign lpddr2_address    = addr_q;
  assign lpddr2_write_data = wdata_q;
  assign p0_rdata          = p0_rdata_q;
  assign p1_rdata          = p1_rdata_q;

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Self-checking bench for lpddr2_port_arbiter: transaction-level model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_lpddr2_port_arbiter;

  localparam int ADDR_W     = 27;
  localparam int DATA_W     = 32;
  localparam int FIXED_PRIO = 0;
  localparam int TIMEOUT    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic              p0_done, p1_done, busy, owner, err;
  logic [ADDR_W-1:0] lpddr2_address;
  logic [DATA_W-1:0] lpddr2_write_data, lpddr2_read_data;
  logic              lpddr2_rreq, lpddr2_wreq, lpddr2_waitreq, lpddr2_rvalid;

  lpddr2_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(FIXED_PRIO), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done),
    .busy(busy), .owner(owner), .err(err),
    .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
    .lpddr2_read_data(lpddr2_read_data), .lpddr2_rreq(lpddr2_rreq),
    .lpddr2_wreq(lpddr2_wreq), .lpddr2_waitreq(lpddr2_waitreq),
    .lpddr2_rvalid(lpddr2_rvalid)
  );

  // Standalone pickers for exhaustive checks of both priority modes.
  logic [1:0] u_req;
  logic       u_last, rr_valid, rr_grant, fx_valid, fx_grant;
  arb_pick2 #(.FIXED_PRIO(0)) u_rr (.req(u_req), .last_grant(u_last), .valid(rr_valid), .grant(rr_grant));
  arb_pick2 #(.FIXED_PRIO(1)) u_fx (.req(u_req), .last_grant(u_last), .valid(fx_valid), .grant(fx_grant));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs for the coming cycle.
  logic [1:0]        nxt_req, nxt_we;
  logic [ADDR_W-1:0] nxt_addr [2];
  logic [DATA_W-1:0] nxt_wdata[2];
  logic              nxt_waitreq, nxt_rvalid;
  logic [DATA_W-1:0] nxt_rdata;

  // Transaction-level model of the arbiter.
  bit                m_valid, m_port, m_we, m_accepted, m_done, m_last, m_owner, m_err;
  int                m_waited;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata[2];

  task automatic model_reset();
    m_valid = 0; m_port = 0; m_we = 0; m_accepted = 0; m_done = 0;
    m_last = 1; m_owner = 0; m_err = 0; m_waited = 0;
    m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic idle_inputs();
    nxt_req = 2'b00; nxt_we = 2'b00;
    nxt_addr[0] = '0; nxt_addr[1] = '0; nxt_wdata[0] = '0; nxt_wdata[1] = '0;
    nxt_waitreq = 1'b0; nxt_rvalid = 1'b0; nxt_rdata = '0;
  endtask

  task automatic drive();
    p0_req = nxt_req[0]; p0_we = nxt_we[0]; p0_addr = nxt_addr[0]; p0_wdata = nxt_wdata[0];
    p1_req = nxt_req[1]; p1_we = nxt_we[1]; p1_addr = nxt_addr[1]; p1_wdata = nxt_wdata[1];
    lpddr2_waitreq = nxt_waitreq; lpddr2_rvalid = nxt_rvalid; lpddr2_read_data = nxt_rdata;
  endtask

  task automatic compare();
    check("busy",       busy,        m_valid);
    check("rreq",       lpddr2_rreq, m_valid && !m_accepted && !m_we);
    check("wreq",       lpddr2_wreq, m_valid && !m_accepted &&  m_we);
    check("p0_done",    p0_done,     m_valid && m_done && (m_port == 0));
    check("p1_done",    p1_done,     m_valid && m_done && (m_port == 1));
    check("owner",      owner,       m_owner);
    check("address",    lpddr2_address,    m_addr);
    check("write_data", lpddr2_write_data, m_wdata);
    check("p0_rdata",   p0_rdata,    m_rdata[0]);
    check("p1_rdata",   p1_rdata,    m_rdata[1]);
    check("err",        err,         m_err);
  endtask

  // What one rising edge does to the in-flight transaction, given this cycle's inputs.
  task automatic advance();
    bit win;
    if (!m_valid) begin
      if (nxt_req != 2'b00) begin
        if (nxt_req == 2'b11) win = (FIXED_PRIO != 0) ? 1'b1 : !m_last;
        else                  win = nxt_req[1];
        m_valid = 1; m_port = win; m_owner = win; m_accepted = 0; m_done = 0;
        m_we = nxt_we[win]; m_addr = nxt_addr[win]; m_wdata = nxt_wdata[win];
      end
    end else if (m_done) begin
      m_valid = 0; m_done = 0; m_last = m_port;
    end else if (!m_accepted) begin
      if (!nxt_waitreq) begin
        m_accepted = 1; m_waited = 0;
        if (m_we) m_done = 1;
      end
    end else if (nxt_rvalid) begin
      m_rdata[m_port] = nxt_rdata; m_done = 1;
    end else begin
      m_waited++;
`ifdef LPDDR2_ARB_TIMEOUT_EN
      if (m_waited == TIMEOUT) begin
        m_rdata[m_port] = 32'hDEAD_BEEF; m_err = 1; m_done = 1;
      end
`endif
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    drive();
    advance();
  endtask

  // One directed transaction; statistics come from observing the DUT pins.
  task automatic run_txn(input int port, input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int stall, input int rlat,
                         input logic [DATA_W-1:0] rd,
                         output int n_rreq, output int n_wreq, output int n_done0,
                         output int n_done1, output int lat, output bit stable,
                         output logic [DATA_W-1:0] rdata_seen);
    int stall_left, rv_in, acc_at, done_at, t;
    stall_left = stall; rv_in = 0; acc_at = -1; done_at = -1; t = 0;
    n_rreq = 0; n_wreq = 0; n_done0 = 0; n_done1 = 0; stable = 1; rdata_seen = '0;
    idle_inputs();
    nxt_req[port] = 1'b1; nxt_we[port] = we; nxt_addr[port] = addr; nxt_wdata[port] = wd;
    nxt_waitreq = (stall_left > 0);
    while (t < 60 && !(done_at >= 0 && t >= done_at + 3)) begin
      step();
      if (lpddr2_rreq) n_rreq++;
      if (lpddr2_wreq) n_wreq++;
      if (lpddr2_rreq || lpddr2_wreq) begin
        if (lpddr2_address !== addr || (we && lpddr2_write_data !== wd)) stable = 0;
        if (lpddr2_waitreq) begin
          if (stall_left > 0) stall_left--;
        end else if (acc_at < 0) begin
          acc_at = t; rv_in = rlat;
        end
      end
      if (p0_done) n_done0++;
      if (p1_done) n_done1++;
      if ((p0_done || p1_done) && done_at < 0) begin
        done_at = t;
        rdata_seen = (port == 1) ? p1_rdata : p0_rdata;
        nxt_req[port] = 1'b0;
      end
      nxt_waitreq = (stall_left > 0);
      nxt_rvalid  = (rv_in == 1);
      nxt_rdata   = (rv_in == 1) ? rd : DATA_W'($urandom);
      if (rv_in > 0) rv_in--;
      t++;
    end
    check("txn_completed", done_at >= 0, 1'b1);
    lat = (done_at >= 0 && acc_at >= 0) ? done_at - acc_at : -1;
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nr, nw, d0, d1, lat;
    bit stable;
    logic [DATA_W-1:0] rseen;
    bit last_g;
    int order[4];
    int exp_order[4];
    int nd;
    int rv_pending;

    // Exhaustive picker check, both priority modes.
    for (int i = 0; i < 8; i++) begin
      u_req = 2'(i); u_last = i[2];
      #1;
      check("pick_rr_valid", rr_valid, u_req != 2'b00);
      check("pick_fx_valid", fx_valid, u_req != 2'b00);
      if (u_req != 2'b00) begin
        check("pick_rr_grant", rr_grant, (u_req == 2'b11) ? !u_last : u_req[1]);
        check("pick_fx_grant", fx_grant, (u_req == 2'b11) ? 1'b1 : u_req[1]);
      end
    end
    u_req = 2'b11; last_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      u_last = last_g; #1;
      check($sformatf("fixed_tie_%0d", i), fx_grant, 1'b1);
      last_g = fx_grant;
    end

    // Reset state.
    rst = 1'b0;
    idle_inputs(); drive(); model_reset();
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {lpddr2_rreq, lpddr2_wreq}, 2'b00);
    check("rst_done", {p0_done, p1_done}, 2'b00);
    check("rst_owner", owner, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_address", lpddr2_address, 27'h0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    @(negedge clk); rst = 1'b1;

    // Single read on port 0, rvalid two cycles after acceptance.
    run_txn(0, 0, 27'h10, 32'h0, 0, 2, 32'h1234_5678, nr, nw, d0, d1, lat, stable, rseen);
    check("rd_rreq_cycles", nr, 1);
    check("rd_wreq_cycles", nw, 0);
    check("rd_p0_done", d0, 1);
    check("rd_p1_done", d1, 0);
    check("rd_accept_to_done", lat, 3);
    check("rd_addr", stable, 1'b1);
    check("rd_rdata", rseen, 32'h1234_5678);

    // Write on port 1 stalled for four cycles.
    run_txn(1, 1, 27'h20, 32'hCAFE_0001, 4, 0, 32'h0, nr, nw, d0, d1, lat, stable, rseen);
    check("wr_wreq_cycles", nw, 5);
    check("wr_rreq_cycles", nr, 0);
    check("wr_p1_done", d1, 1);
    check("wr_p0_done", d0, 0);
    check("wr_accept_to_done", lat, 1);
    check("wr_stable", stable, 1'b1);

    // Both ports held high: round-robin alternates starting with port 0.
    exp_order = '{0, 1, 0, 1};
    order = '{0, 0, 0, 0};
    nd = 0;
    idle_inputs();
    nxt_req = 2'b11; nxt_we = 2'b11; nxt_addr[0] = 27'h100; nxt_addr[1] = 27'h200;
    nxt_wdata[0] = 32'hA0A0_A0A0; nxt_wdata[1] = 32'hB1B1_B1B1;
    for (int t = 0; t < 60 && nd < 4; t++) begin
      step();
      if (p0_done)      begin order[nd] = 0; nd++; end
      else if (p1_done) begin order[nd] = 1; nd++; end
    end
    idle_inputs();
    step(); step();
    check("tie_count", nd, 4);
    for (int i = 0; i < 4; i++) check($sformatf("tie_order_%0d", i), order[i], exp_order[i]);

    // Stray rvalid while idle.
    nd = 0;
    nxt_rvalid = 1'b1; nxt_rdata = 32'hFFFF_FFFF;
    for (int t = 0; t < 3; t++) begin
      step();
      if (p0_done || p1_done) nd++;
    end
    idle_inputs();
    step();
    check("stray_no_done", nd, 0);
    check("stray_p0_rdata", p0_rdata, 32'h1234_5678);
    check("stray_p1_rdata", p1_rdata, 32'h0);

    // Reset while waiting for read data.
    idle_inputs();
    nxt_req[0] = 1'b1; nxt_addr[0] = 27'h5;
    step(); step(); step();
    check("mid_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_strobes", {lpddr2_rreq, lpddr2_wreq}, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", {p0_done, p1_done}, 2'b00);
    idle_inputs(); drive(); model_reset();
    step();
    rst = 1'b1;
    nxt_rvalid = 1'b1; nxt_rdata = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    nd = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (p0_done || p1_done) nd++;
    end
    check("late_rvalid_no_done", nd, 0);
    check("late_rvalid_rdata", p0_rdata, 32'h0);

`ifdef LPDDR2_ARB_TIMEOUT_EN
    run_txn(0, 0, 27'h30, 32'h0, 0, 0, 32'h0, nr, nw, d0, d1, lat, stable, rseen);
    check("to_done", d0, 1);
    check("to_accept_to_done", lat, TIMEOUT + 1);
    check("to_rdata", rseen, 32'hDEAD_BEEF);
    check("to_err", err, 1'b1);
    run_txn(1, 1, 27'h31, 32'h1, 0, 0, 32'h0, nr, nw, d0, d1, lat, stable, rseen);
    check("to_err_sticky", err, 1'b1);
`endif

    // Randomized traffic against the model.
    idle_inputs();
    rv_pending = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (lpddr2_rreq && !lpddr2_waitreq) rv_pending = $urandom_range(1, 4);
      for (int p = 0; p < 2; p++) begin
        if (nxt_req[p] && (p == 0 ? p0_done : p1_done)) begin
          nxt_req[p] = 1'b0;
        end else if (nxt_req[p] && $urandom_range(0, 49) == 0) begin
          nxt_req[p] = 1'b0;
        end else if (!nxt_req[p] && $urandom_range(0, 2) == 0) begin
          nxt_req[p]   = 1'b1;
          nxt_we[p]    = 1'($urandom_range(0, 1));
          nxt_addr[p]  = ADDR_W'($urandom);
          nxt_wdata[p] = DATA_W'($urandom);
        end
      end
      nxt_waitreq = ($urandom_range(0, 9) < 3);
      nxt_rvalid  = (rv_pending == 1) || ($urandom_range(0, 19) == 0);
      nxt_rdata   = DATA_W'($urandom);
      if (rv_pending > 0) rv_pending--;
    end
    idle_inputs();
    for (int t = 0; t < 8; t++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
